// File: rtl/par_to_ser_param.sv
// -----------------------------------------------------------------------------
// par_to_ser_param
//   Parametrised parallel-to-serial transmitter. One WIDTH-bit word is shifted
//   onto a 1-bit line every WIDTH clk cycles. After reset a preamble of
//   SYNC_WORDS idle words is sent before data is accepted. Whenever no word is
//   accepted at a word boundary, IDLE_SYM is sent instead, so the line never
//   has a gap.
//
// Parameters
//   WIDTH       bits per word (>= 2)
//   IDLE_SYM    word transmitted when no data is accepted
//   SYNC_WORDS  idle words sent after reset before ready may assert (0 = none)
//   MSB_FIRST   1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk              in   1      clock, all logic on posedge
//   reset            in   1      asynchronous, active-high reset
//   valid            in   1      data_in holds a word to send
//   data_in          in   WIDTH  parallel word, sampled only on a handshake edge
//   ready            out  1      data_in is accepted at this posedge (combinational)
//   data_out_serial  out  1      serial bit stream
//   word_start       out  1      high while the first bit of a word is on the line
//   data_flag        out  1      high on every bit of a data word, low on idle words
//   dbg_state        out  1      0 = SYNC (preamble), 1 = ACTIVE
//
// Handshake: a word transfers on a posedge where valid && ready are both high.
//   valid may be raised at any time and does not need ready to be high first;
//   ready never depends on valid. data_in is only looked at on a transfer edge.
// -----------------------------------------------------------------------------
module par_to_ser_param #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(8'hBC),
    parameter int              SYNC_WORDS = 4,
    parameter bit              MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             data_out_serial,
    output logic             word_start,
    output logic             data_flag,
    output logic             dbg_state
);

    localparam int BCW = $clog2(WIDTH);
    localparam int SCW = (SYNC_WORDS < 1) ? 1 : $clog2(SYNC_WORDS + 1);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [SCW-1:0] SYNC_MAX = SCW'(SYNC_WORDS);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [BCW-1:0]   r_bit_cnt;
    logic [SCW-1:0]   r_sync_cnt;
    logic             r_word_start;
    logic             r_data_flag;

    logic             w_boundary;
    logic             w_sync_done;
    logic             w_accept;

    assign w_boundary  = (r_bit_cnt == LAST_BIT);
    assign w_sync_done = (r_sync_cnt == SYNC_MAX);

    // The preamble is complete either once the state has moved to ACTIVE or
    // as soon as the idle count has reached its target. The second term only
    // matters at a boundary when SYNC_WORDS is 0: the very first edge after
    // reset then already accepts data. For SYNC_WORDS > 0 the count reaches
    // its target on a boundary edge and the state follows one edge later,
    // well before the next boundary, so both terms agree there.
    assign ready    = ((r_state == ST_ACTIVE) || w_sync_done) && w_boundary && !reset;
    assign w_accept = valid && ready;

    assign data_out_serial = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign word_start      = r_word_start;
    assign data_flag       = r_data_flag;
    assign dbg_state       = (r_state == ST_ACTIVE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state: SYNC leaves once the preamble count is reached; ACTIVE is
    // only left through reset.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC:   if (w_sync_done) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: w_state_nxt = ST_ACTIVE;
            default:   w_state_nxt = ST_SYNC;
        endcase
    end

    // -------------------------------------------------------------------------
    // Shift register, bit counter, preamble counter and per-word flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg       <= '0;
            r_bit_cnt    <= LAST_BIT;
            r_sync_cnt   <= '0;
            r_word_start <= 1'b0;
            r_data_flag  <= 1'b0;
        end else if (w_boundary) begin
            r_bit_cnt    <= '0;
            r_word_start <= 1'b1;
            if (w_accept) begin
                r_sreg      <= data_in;
                r_data_flag <= 1'b1;
            end else begin
                r_sreg      <= IDLE_SYM;
                r_data_flag <= 1'b0;
                // Only idle words sent during the preamble count towards it.
                if ((r_state == ST_SYNC) && !w_sync_done) begin
                    r_sync_cnt <= r_sync_cnt + 1'b1;
                end
            end
        end else begin
            r_bit_cnt    <= r_bit_cnt + 1'b1;
            r_word_start <= 1'b0;
            // Move the next bit into the head position, zero-fill behind it.
            if (MSB_FIRST) begin
                r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
            end else begin
                r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_par_to_ser_param.sv
// -----------------------------------------------------------------------------
// tb_par_to_ser_param
//   Three instances share clk, valid and data_in; each has its own reset:
//     a: WIDTH=8,  IDLE=8'hBC,   SYNC=4, MSB first
//     b: WIDTH=8,  IDLE=8'hBC,   SYNC=0, LSB first
//     c: WIDTH=10, IDLE=10'h17C, SYNC=1, MSB first
//   Only one instance is exercised at a time; sel picks whose outputs the
//   monitor looks at. The driver pushes every expected line bit (with its
//   data_flag and word_start) when it issues a word; the monitor pops one
//   entry per cycle and compares it with the line.
// -----------------------------------------------------------------------------
module tb_par_to_ser_param;

    logic       clk;
    logic       rst_a, rst_b, rst_c;
    logic       valid;
    logic [9:0] data_in;

    logic ready_a, ser_a, ws_a, df_a, dbg_a;
    logic ready_b, ser_b, ws_b, df_b, dbg_b;
    logic ready_c, ser_c, ws_c, df_c, dbg_c;

    par_to_ser_param #(
        .WIDTH(8), .IDLE_SYM(8'hBC), .SYNC_WORDS(4), .MSB_FIRST(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .valid(valid), .data_in(data_in[7:0]),
        .ready(ready_a), .data_out_serial(ser_a), .word_start(ws_a),
        .data_flag(df_a), .dbg_state(dbg_a)
    );

    par_to_ser_param #(
        .WIDTH(8), .IDLE_SYM(8'hBC), .SYNC_WORDS(0), .MSB_FIRST(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .valid(valid), .data_in(data_in[7:0]),
        .ready(ready_b), .data_out_serial(ser_b), .word_start(ws_b),
        .data_flag(df_b), .dbg_state(dbg_b)
    );

    par_to_ser_param #(
        .WIDTH(10), .IDLE_SYM(10'h17C), .SYNC_WORDS(1), .MSB_FIRST(1'b1)
    ) u_dut_c (
        .clk(clk), .reset(rst_c), .valid(valid), .data_in(data_in),
        .ready(ready_c), .data_out_serial(ser_c), .word_start(ws_c),
        .data_flag(df_c), .dbg_state(dbg_c)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ output select
    int   sel;
    logic cur_ready, cur_ser, cur_ws, cur_df, cur_dbg;

    always_comb begin
        cur_ready = ready_a;
        cur_ser   = ser_a;
        cur_ws    = ws_a;
        cur_df    = df_a;
        cur_dbg   = dbg_a;
        case (sel)
            1: begin
                cur_ready = ready_b; cur_ser = ser_b; cur_ws = ws_b;
                cur_df = df_b; cur_dbg = dbg_b;
            end
            2: begin
                cur_ready = ready_c; cur_ser = ser_c; cur_ws = ws_c;
                cur_df = df_c; cur_dbg = dbg_c;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- scoreboard
    // Entry = {line bit, data_flag, word_start}
    logic [2:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t, sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    logic [2:0] mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("line{bit,flag,start}", {29'd0, cur_ser, cur_df, cur_ws}, {29'd0, mon_e});
        end
    end

    // ---------------------------------------------------------- bench model
    int         cfg_w;
    bit         cfg_msb;
    int         cfg_sync;
    logic [9:0] cfg_idle;
    int         wcnt;     // words sent since the last reset release

    // Called in a boundary cycle (just after the edge that completes the
    // previous word). Drives one word, returns in the next boundary cycle.
    // At bit index chg_at of the word, valid/data_in are changed to v2/d2.
    task automatic send_word(input logic v, input logic [9:0] d, input int chg_at,
                             input logic v2, input logic [9:0] d2);
        logic       acc;
        logic       b;
        logic [9:0] word;
        acc     = v && (wcnt >= cfg_sync);
        word    = acc ? d : cfg_idle;
        valid   = v;
        data_in = d;
        #1;
        check("ready_at_boundary", {31'd0, cur_ready}, {31'd0, (wcnt >= cfg_sync)});
        @(posedge clk); #1;
        for (int i = 0; i < cfg_w; i++) begin
            b = cfg_msb ? word[cfg_w-1-i] : word[i];
            exp_q.push_back({b, acc, (i == 0)});
        end
        wcnt++;
        for (int j = 1; j < cfg_w; j++) begin
            check("ready_midword", {31'd0, cur_ready}, 32'd0);
            @(posedge clk); #1;
            if (j == chg_at) begin
                valid   = v2;
                data_in = d2;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_line"},  {31'd0, cur_ser},   32'd0);
        check({tag, "_ready"}, {31'd0, cur_ready}, 32'd0);
        check({tag, "_flag"},  {31'd0, cur_df},    32'd0);
        check({tag, "_start"}, {31'd0, cur_ws},    32'd0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk); #1;
        check({tag, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic report();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        n_errors++;
        report();
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        n_checks = 0;
        n_errors = 0;
        sel      = 0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        rst_c    = 1'b1;
        valid    = 1'b1;
        data_in  = 10'h0AA;

        // ---- 1: instance a, reset held 3 cycles, released with valid/AA
        cfg_w = 8; cfg_msb = 1'b1; cfg_sync = 4; cfg_idle = 10'h0BC;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("a_reset");
        end
        @(posedge clk); #1;
        rst_a = 1'b0;
        wcnt  = 0;
        // Preamble: valid stays high but four idle words go out first.
        repeat (4) send_word(1'b1, 10'h0AA, -1, 1'b0, 10'h0);
        check("a_state_active", {31'd0, cur_dbg}, 32'd1);

        // ---- 2: AA held for three words, gapless data
        repeat (3) send_word(1'b1, 10'h0AA, -1, 1'b0, 10'h0);

        // ---- 3: valid dropped mid-word -> idle word follows
        send_word(1'b1, 10'h0AA, 2, 1'b0, 10'h0AA);
        send_word(1'b0, 10'h0AA, -1, 1'b0, 10'h0);

        // ---- 4: data_in changes 3 cycles after the handshake
        send_word(1'b1, 10'h0AA, 3, 1'b1, 10'h0AB);
        send_word(1'b1, 10'h0AB, -1, 1'b0, 10'h0);

        // ---- 6: reset in the middle of a data word (bit 3 on the line)
        valid   = 1'b1;
        data_in = 10'h0FF;
        #1;
        check("a_ready_before_abort", {31'd0, cur_ready}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 1'b1, (i == 0)});
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        rst_a = 1'b1;
        #1;
        check_reset_outputs("a_abort");
        check("a_abort_state", {31'd0, cur_dbg}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_a   = 1'b0;
        wcnt    = 0;
        repeat (4) send_word(1'b1, 10'h05A, -1, 1'b0, 10'h0);
        send_word(1'b1, 10'h05A, -1, 1'b0, 10'h0);
        send_word(1'b0, 10'h05A, -1, 1'b0, 10'h0);
        drain("a");
        rst_a = 1'b1;

        // ---- 5: instance b, LSB first, no preamble, AB in the first word
        sel = 1;
        cfg_w = 8; cfg_msb = 1'b0; cfg_sync = 0; cfg_idle = 10'h0BC;
        valid   = 1'b1;
        data_in = 10'h0AB;
        @(negedge clk); #1;
        check_reset_outputs("b_reset");
        @(posedge clk); #1;
        rst_b = 1'b0;
        wcnt  = 0;
        send_word(1'b1, 10'h0AB, -1, 1'b0, 10'h0);
        send_word(1'b0, 10'h0AB, -1, 1'b0, 10'h0);
        send_word(1'b1, 10'h0C3, -1, 1'b0, 10'h0);
        drain("b");
        rst_b = 1'b1;

        // ---- 7: instance c, 10-bit frames, one idle word of preamble
        sel = 2;
        cfg_w = 10; cfg_msb = 1'b1; cfg_sync = 1; cfg_idle = 10'h17C;
        valid   = 1'b1;
        data_in = 10'h2A5;
        @(negedge clk); #1;
        check_reset_outputs("c_reset");
        @(posedge clk); #1;
        rst_c = 1'b0;
        wcnt  = 0;
        send_word(1'b1, 10'h2A5, -1, 1'b0, 10'h0);
        send_word(1'b1, 10'h2A5, -1, 1'b0, 10'h0);
        send_word(1'b1, 10'h2A5, -1, 1'b0, 10'h0);
        send_word(1'b0, 10'h2A5, -1, 1'b0, 10'h0);
        drain("c");
        rst_c = 1'b1;

        report();
        $finish;
    end

endmodule
